axis_packet_arbiter: RTL and testbench

AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

---
 rtl/axis_packet_arbiter.sv | 133 +++++++++++++
 tb/tb_axis_packet_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_arbiter.sv
// rtl/axis_packet_arbiter.sv - round-robin packet arbiter merging N AXIS inputs onto one output
// Optional per-input packet counters: define AXIS_PACKET_ARBITER_PKT_COUNT_EN to add pkt_count.
module axis_packet_arbiter #(
  parameter int N_INPUTS   = 2,
  parameter int AXIS_BYTES = 1
) (
  input  logic                             clk,
  input  logic                             sresetn,
  output logic [N_INPUTS-1:0]              axis_i_tready,
  input  logic [N_INPUTS-1:0]              axis_i_tvalid,
  input  logic [N_INPUTS-1:0]              axis_i_tlast,
  input  logic [N_INPUTS*AXIS_BYTES*8-1:0] axis_i_tdata,
  input  logic                             axis_o_tready,
  output logic                             axis_o_tvalid,
  output logic                             axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0]          axis_o_tdata,
  output logic [N_INPUTS-1:0]              grant
`ifdef AXIS_PACKET_ARBITER_PKT_COUNT_EN
  ,
  output logic [N_INPUTS*16-1:0]           pkt_count
`endif
);

  localparam int DW = AXIS_BYTES * 8;
  localparam int PW = $clog2(N_INPUTS);

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [N_INPUTS-1:0] grant_q, grant_d;
  logic [PW-1:0]       gidx_q, gidx_d;
  logic [PW-1:0]       last_grant_q, last_grant_d;
  logic                last_hs;
  logic                found;
  int                  idx;

  // A packet ends on the granted input's tlast handshake
  assign last_hs = (state_q == PASS) && axis_i_tvalid[gidx_q] &&
                   axis_o_tready && axis_i_tlast[gidx_q];

  // Next-state: round-robin pick in IDLE, hold the lock in PASS until tlast
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    last_grant_d = last_grant_q;
    found        = 1'b0;
    idx          = 0;
    case (state_q)
      IDLE: begin
        for (int i = 1; i <= N_INPUTS; i++) begin
          idx = (int'(last_grant_q) + i) % N_INPUTS;
          if (!found && axis_i_tvalid[idx]) begin
            found        = 1'b1;
            gidx_d       = PW'(idx);
            grant_d      = '0;
            grant_d[idx] = 1'b1;
            state_d      = PASS;
          end
        end
      end
      PASS: begin
        if (last_hs) begin
          state_d      = IDLE;
          grant_d      = '0;
          last_grant_d = gidx_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // FSM and grant registers; reset points last_grant at N-1 so input 0 wins first
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      last_grant_q <= PW'(N_INPUTS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign grant = grant_q;

  // Combinational pass-through of the locked input; nothing moves in IDLE
  always_comb begin
    axis_o_tvalid = 1'b0;
    axis_o_tlast  = 1'b0;
    axis_o_tdata  = '0;
    axis_i_tready = '0;
    if (state_q == PASS) begin
      axis_o_tvalid         = axis_i_tvalid[gidx_q];
      axis_o_tlast          = axis_i_tlast[gidx_q];
      axis_o_tdata          = axis_i_tdata[int'(gidx_q)*DW +: DW];
      axis_i_tready[gidx_q] = axis_o_tready;
    end
  end

`ifdef AXIS_PACKET_ARBITER_PKT_COUNT_EN
  logic [N_INPUTS*16-1:0] pkt_count_q, pkt_count_d;

  // Bump the owner's 16-bit counter on each completed packet, wrapping naturally
  always_comb begin
    pkt_count_d = pkt_count_q;
    if (last_hs) begin
      pkt_count_d[int'(gidx_q)*16 +: 16] = pkt_count_q[int'(gidx_q)*16 +: 16] + 16'd1;
    end
  end

  // Packet counter registers
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      pkt_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
    end
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb/tb_axis_packet_arbiter.sv - directed self-checking bench for axis_packet_arbiter
module tb_axis_packet_arbiter;

  logic clk = 1'b0;
  logic sresetn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: two inputs
  logic [1:0]  a_i_tready, a_i_tvalid, a_i_tlast, a_grant;
  logic [15:0] a_i_tdata;
  logic        a_o_tready, a_o_tvalid, a_o_tlast;
  logic [7:0]  a_o_tdata;
  // DUT B: three inputs
  logic [2:0]  b_i_tready, b_i_tvalid, b_i_tlast, b_grant;
  logic [23:0] b_i_tdata;
  logic        b_o_tready, b_o_tvalid, b_o_tlast;
  logic [7:0]  b_o_tdata;
`ifdef AXIS_PACKET_ARBITER_PKT_COUNT_EN
  logic [31:0] a_pkt_count;
  logic [47:0] b_pkt_count;
`endif

  axis_packet_arbiter #(.N_INPUTS(2), .AXIS_BYTES(1)) u_a (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(a_i_tready), .axis_i_tvalid(a_i_tvalid), .axis_i_tlast(a_i_tlast),
    .axis_i_tdata(a_i_tdata), .axis_o_tready(a_o_tready), .axis_o_tvalid(a_o_tvalid),
    .axis_o_tlast(a_o_tlast), .axis_o_tdata(a_o_tdata), .grant(a_grant)
`ifdef AXIS_PACKET_ARBITER_PKT_COUNT_EN
    , .pkt_count(a_pkt_count)
`endif
  );

  axis_packet_arbiter #(.N_INPUTS(3), .AXIS_BYTES(1)) u_b (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tready(b_i_tready), .axis_i_tvalid(b_i_tvalid), .axis_i_tlast(b_i_tlast),
    .axis_i_tdata(b_i_tdata), .axis_o_tready(b_o_tready), .axis_o_tvalid(b_o_tvalid),
    .axis_o_tlast(b_o_tlast), .axis_o_tdata(b_o_tdata), .grant(b_grant)
`ifdef AXIS_PACKET_ARBITER_PKT_COUNT_EN
    , .pkt_count(b_pkt_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    sresetn = 1'b0;
    a_i_tvalid = '0; a_i_tlast = '0; a_i_tdata = '0; a_o_tready = 1'b1;
    b_i_tvalid = '0; b_i_tlast = '0; b_i_tdata = '0; b_o_tready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (a_grant !== 2'b00) begin errors++; $display("FAIL reset_grant_a: got %b expected 00", a_grant); end
    checks++;
    if (a_o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid_a: got %b expected 0", a_o_tvalid); end
    checks++;
    if (a_i_tready !== 2'b00) begin errors++; $display("FAIL reset_tready_a: got %b expected 00", a_i_tready); end
    checks++;
    if (b_grant !== 3'b000) begin errors++; $display("FAIL reset_grant_b: got %b expected 000", b_grant); end
    sresetn = 1'b1;
    tick();
  endtask

  task automatic test_single_requester();
    logic [7:0] beats [8];
    beats = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hCA, 8'hFE};
    a_o_tready = 1'b1;
    a_i_tvalid = 2'b10; a_i_tlast = 2'b00; a_i_tdata = {beats[0], 8'h00};
    settle();
    checks++;
    if (a_o_tvalid !== 1'b0 || a_i_tready !== 2'b00 || a_grant !== 2'b00) begin
      errors++; $display("FAIL single_idle: got tvalid=%b tready=%b grant=%b expected 0,00,00", a_o_tvalid, a_i_tready, a_grant);
    end
    tick();
    checks++;
    if (a_grant !== 2'b10) begin errors++; $display("FAIL single_grant: got %b expected 10", a_grant); end
    for (int k = 0; k < 8; k++) begin
      a_i_tdata = {beats[k], 8'h00};
      a_i_tlast = (k == 7) ? 2'b10 : 2'b00;
      settle();
      checks++;
      if (a_o_tvalid !== 1'b1 || a_o_tdata !== beats[k] || a_o_tlast !== (k == 7) || a_i_tready !== 2'b10) begin
        errors++;
        $display("FAIL single_beat%0d: got tvalid=%b data=%h tlast=%b tready=%b expected 1,%h,%b,10",
                 k, a_o_tvalid, a_o_tdata, a_o_tlast, a_i_tready, beats[k], (k == 7));
      end
      tick();
    end
    a_i_tvalid = 2'b00; a_i_tlast = 2'b00;
    settle();
    checks++;
    if (a_grant !== 2'b00 || a_o_tvalid !== 1'b0) begin
      errors++; $display("FAIL single_back_idle: got grant=%b tvalid=%b expected 00,0", a_grant, a_o_tvalid);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int k = 0;
    a_i_tvalid = 2'b11; a_i_tlast = 2'b10; a_i_tdata = {8'hEE, 8'h10}; a_o_tready = 1'b1;
    tick();
    settle();
    checks++;
    if (a_grant !== 2'b01) begin errors++; $display("FAIL bp_grant: got %b expected 01", a_grant); end
    for (int c = 0; c < 40 && k < 6; c++) begin
      a_o_tready = (c % 2 == 0);
      settle();
      checks++;
      if (a_i_tready !== {1'b0, a_o_tready}) begin
        errors++; $display("FAIL bp_tready_c%0d: got %b expected %b", c, a_i_tready, {1'b0, a_o_tready});
      end
      if (a_o_tvalid && a_o_tready) begin
        checks++;
        if (a_o_tdata !== 8'(8'h10 + k) || a_o_tlast !== (k == 5)) begin
          errors++; $display("FAIL bp_beat%0d: got data=%h tlast=%b expected %h,%b", k, a_o_tdata, a_o_tlast, 8'(8'h10 + k), (k == 5));
        end
        k++;
      end
      tick();
      if (k < 6) begin
        a_i_tdata[7:0] = 8'(8'h10 + k);
        a_i_tlast[0] = (k == 5);
      end else begin
        a_i_tvalid = 2'b00; a_i_tlast = 2'b00;
      end
    end
    a_i_tvalid = 2'b00;
    settle();
    checks++;
    if (k !== 6) begin errors++; $display("FAIL bp_beat_count: got %0d expected 6", k); end
    checks++;
    if (a_grant !== 2'b00) begin errors++; $display("FAIL bp_back_idle: got %b expected 00", a_grant); end
    a_o_tready = 1'b1;
    tick();
  endtask

  task automatic test_mid_packet_gap();
    a_o_tready = 1'b1;
    a_i_tvalid = 2'b01; a_i_tlast = 2'b00; a_i_tdata = {8'hB0, 8'hA0};
    tick();
    a_i_tvalid = 2'b11; a_i_tlast = 2'b10;
    settle();
    checks++;
    if (a_grant !== 2'b01 || a_o_tdata !== 8'hA0) begin
      errors++; $display("FAIL gap_grant: got grant=%b data=%h expected 01,a0", a_grant, a_o_tdata);
    end
    tick();
    a_i_tdata[7:0] = 8'hA1;
    settle();
    checks++;
    if (a_o_tdata !== 8'hA1 || a_o_tvalid !== 1'b1) begin
      errors++; $display("FAIL gap_beat1: got data=%h tvalid=%b expected a1,1", a_o_tdata, a_o_tvalid);
    end
    tick();
    a_i_tvalid[0] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      settle();
      checks++;
      if (a_o_tvalid !== 1'b0 || a_grant !== 2'b01 || a_i_tready !== 2'b01) begin
        errors++; $display("FAIL gap_hold_c%0d: got tvalid=%b grant=%b tready=%b expected 0,01,01", c, a_o_tvalid, a_grant, a_i_tready);
      end
      tick();
    end
    a_i_tvalid[0] = 1'b1; a_i_tdata[7:0] = 8'hA2;
    settle();
    checks++;
    if (a_o_tdata !== 8'hA2 || a_o_tvalid !== 1'b1) begin
      errors++; $display("FAIL gap_beat2: got data=%h tvalid=%b expected a2,1", a_o_tdata, a_o_tvalid);
    end
    tick();
    a_i_tdata[7:0] = 8'hA3; a_i_tlast[0] = 1'b1;
    settle();
    checks++;
    if (a_o_tdata !== 8'hA3 || a_o_tlast !== 1'b1 || a_grant !== 2'b01) begin
      errors++; $display("FAIL gap_beat3: got data=%h tlast=%b grant=%b expected a3,1,01", a_o_tdata, a_o_tlast, a_grant);
    end
    tick();
    a_i_tvalid = 2'b10;
    settle();
    checks++;
    if (a_grant !== 2'b00) begin errors++; $display("FAIL gap_bubble: got %b expected 00", a_grant); end
    tick();
    settle();
    checks++;
    if (a_grant !== 2'b10 || a_o_tdata !== 8'hB0 || a_o_tlast !== 1'b1 || a_o_tvalid !== 1'b1) begin
      errors++; $display("FAIL gap_second: got grant=%b data=%h tlast=%b tvalid=%b expected 10,b0,1,1", a_grant, a_o_tdata, a_o_tlast, a_o_tvalid);
    end
    tick();
    a_i_tvalid = 2'b00; a_i_tlast = 2'b00;
    settle();
    checks++;
    if (a_grant !== 2'b00) begin errors++; $display("FAIL gap_single_beat_done: got %b expected 00", a_grant); end
    tick();
  endtask

  task automatic test_reset_mid_packet();
    a_o_tready = 1'b1;
    a_i_tvalid = 2'b01; a_i_tlast = 2'b01; a_i_tdata = {8'hC0, 8'h55};
    tick();
    tick();
    a_i_tvalid = 2'b10; a_i_tlast = 2'b00;
    tick();
    settle();
    checks++;
    if (a_grant !== 2'b10) begin errors++; $display("FAIL rst_pre_grant: got %b expected 10", a_grant); end
    tick();
    a_i_tdata[15:8] = 8'hC1;
    tick();
    a_i_tdata[15:8] = 8'hC2;
    settle();
    checks++;
    if (a_o_tvalid !== 1'b1 || a_o_tdata !== 8'hC2) begin
      errors++; $display("FAIL rst_beat3: got tvalid=%b data=%h expected 1,c2", a_o_tvalid, a_o_tdata);
    end
    sresetn = 1'b0;
    tick();
    checks++;
    if (a_o_tvalid !== 1'b0 || a_grant !== 2'b00 || a_i_tready !== 2'b00) begin
      errors++; $display("FAIL rst_abandon: got tvalid=%b grant=%b tready=%b expected 0,00,00", a_o_tvalid, a_grant, a_i_tready);
    end
    a_i_tvalid = 2'b11; a_i_tlast = 2'b11;
    tick();
    sresetn = 1'b1;
    settle();
    checks++;
    if (a_grant !== 2'b00) begin errors++; $display("FAIL rst_no_early_grant: got %b expected 00", a_grant); end
    tick();
    checks++;
    if (a_grant !== 2'b01) begin errors++; $display("FAIL rst_first_grant: got %b expected 01", a_grant); end
    tick();
    a_i_tvalid = 2'b00; a_i_tlast = 2'b00;
    tick();
  endtask

  task automatic test_round_robin();
    int bc [3];
    int exp_idx;
    logic [2:0] hs;
    sresetn = 1'b0;
    b_o_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bc[i] = 0;
      b_i_tdata[i*8 +: 8] = 8'(i * 16);
      b_i_tlast[i] = 1'b0;
    end
    b_i_tvalid = 3'b111;
    tick(); tick();
    sresetn = 1'b1;
    for (int p = 0; p < 6; p++) begin
      exp_idx = p % 3;
      settle();
      checks++;
      if (b_grant !== 3'b000 || b_o_tvalid !== 1'b0) begin
        errors++; $display("FAIL rr_bubble_p%0d: got grant=%b tvalid=%b expected 000,0", p, b_grant, b_o_tvalid);
      end
      tick();
      for (int bt = 0; bt < 4; bt++) begin
        settle();
        checks++;
        if (b_grant !== 3'(1 << exp_idx) || b_o_tvalid !== 1'b1 ||
            b_o_tdata !== 8'(exp_idx * 16 + bt) || b_o_tlast !== (bt == 3)) begin
          errors++;
          $display("FAIL rr_p%0d_b%0d: got grant=%b tvalid=%b data=%h tlast=%b expected %b,1,%h,%b",
                   p, bt, b_grant, b_o_tvalid, b_o_tdata, b_o_tlast, 3'(1 << exp_idx), 8'(exp_idx * 16 + bt), (bt == 3));
        end
        hs = b_i_tready & b_i_tvalid;
        tick();
        for (int i = 0; i < 3; i++) begin
          if (hs[i]) bc[i] = (bc[i] + 1) % 4;
          b_i_tdata[i*8 +: 8] = 8'(i * 16 + bc[i]);
          b_i_tlast[i] = (bc[i] == 3);
        end
      end
    end
    b_i_tvalid = 3'b000; b_i_tlast = 3'b000;
    tick();
  endtask

`ifdef AXIS_PACKET_ARBITER_PKT_COUNT_EN
  task automatic test_pkt_count();
    int hs_cnt = 0;
    sresetn = 1'b0;
    a_i_tvalid = 2'b00; a_i_tlast = 2'b00; a_o_tready = 1'b1;
    tick();
    sresetn = 1'b1;
    a_i_tvalid = 2'b01; a_i_tlast = 2'b01;
    for (int c = 0; c < 140000 && hs_cnt < 65537; c++) begin
      settle();
      if (a_o_tvalid && a_o_tready && a_o_tlast) hs_cnt++;
      tick();
    end
    a_i_tvalid = 2'b00; a_i_tlast = 2'b00;
    tick();
    checks++;
    if (hs_cnt !== 65537) begin errors++; $display("FAIL cnt_packets_sent: got %0d expected 65537", hs_cnt); end
    checks++;
    if (a_pkt_count[15:0] !== 16'd1) begin errors++; $display("FAIL cnt_wrap_in0: got %0d expected 1", a_pkt_count[15:0]); end
    checks++;
    if (a_pkt_count[31:16] !== 16'd0) begin errors++; $display("FAIL cnt_in1: got %0d expected 0", a_pkt_count[31:16]); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_requester();
    test_backpressure();
    test_mid_packet_gap();
    test_reset_mid_packet();
    test_round_robin();
`ifdef AXIS_PACKET_ARBITER_PKT_COUNT_EN
    test_pkt_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
